// File: rtl/cpu_core_param.sv
// Multi-cycle parametrised accumulator core: fetch over a request/valid port, then execute one of 16 opcodes.
// Latency: one FETCH cycle plus one per memory wait cycle, then one EXEC cycle.
// Backpressure: imem_req and imem_addr are held until imem_valid arrives; run gates progress between instructions only.
module cpu_core_param #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_valid,
  input  logic [DATA_W+3:0]   imem_rdata,
  input  logic [DATA_W-1:0]   sw_in,
  output logic [DATA_W-1:0]   out_port,
  output logic                out_valid,
  output logic                cf,
  output logic                halted,
  output logic [ADDR_W-1:0]   ip
);

  // Jump targets are taken from the low ADDR_W bits of the immediate.
  if (DATA_W < ADDR_W) begin : g_width_check
    $error("cpu_core_param: DATA_W must be >= ADDR_W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD_AI = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_AI = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_BI = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_BI = 4'b0111,
    OP_SUB_AI = 4'b1000,
    OP_OUT_B  = 4'b1001,
    OP_HALT   = 4'b1010,
    OP_OUT_I  = 4'b1011,
    OP_JC     = 4'b1100,
    OP_ADD_AB = 4'b1101,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } opcode_e;

  state_e              state_q;
  logic                req_q;
  logic                halted_q;
  logic                out_valid_q;
  logic [DATA_W+3:0]   instr_q;
  logic [DATA_W-1:0]   a_q, b_q, out_q;
  logic                cf_q;
  logic [ADDR_W-1:0]   ip_q;

  logic [DATA_W-1:0]   a_d, b_d, out_d;
  logic                cf_d;
  logic [ADDR_W-1:0]   ip_d;
  logic                out_vld_d;

  opcode_e             op;
  logic [DATA_W-1:0]   imm;
  logic [ADDR_W-1:0]   ip_inc;
  logic [ADDR_W-1:0]   jmp_tgt;
  logic [DATA_W:0]     sum_ai, sum_bi, sum_ab;

  assign op      = opcode_e'(instr_q[DATA_W+3:DATA_W]);
  assign imm     = instr_q[DATA_W-1:0];
  assign ip_inc  = ip_q + ADDR_W'(1);
  assign jmp_tgt = imm[ADDR_W-1:0];
  assign sum_ai  = {1'b0, a_q} + {1'b0, imm};
  assign sum_bi  = {1'b0, b_q} + {1'b0, imm};
  assign sum_ab  = {1'b0, a_q} + {1'b0, b_q};

  // Architectural next state for the latched instruction; only committed in EXEC.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    out_d     = out_q;
    cf_d      = 1'b0;
    ip_d      = ip_inc;
    out_vld_d = 1'b0;
    case (op)
      OP_ADD_AI: {cf_d, a_d} = sum_ai;
      OP_MOV_AB: a_d = b_q;
      OP_IN_A:   a_d = sw_in;
      OP_MOV_AI: a_d = imm;
      OP_MOV_BA: b_d = a_q;
      OP_ADD_BI: {cf_d, b_d} = sum_bi;
      OP_IN_B:   b_d = sw_in;
      OP_MOV_BI: b_d = imm;
      OP_SUB_AI: begin
        a_d  = a_q - imm;
        cf_d = (imm > a_q);
      end
      OP_OUT_B: begin
        out_d     = b_q;
        out_vld_d = 1'b1;
      end
      OP_HALT:   ip_d = ip_q;
      OP_OUT_I: begin
        out_d     = imm;
        out_vld_d = 1'b1;
      end
      OP_JC:     ip_d = cf_q ? jmp_tgt : ip_inc;
      OP_ADD_AB: {cf_d, a_d} = sum_ab;
      OP_JNC:    ip_d = cf_q ? ip_inc : jmp_tgt;
      OP_JMP:    ip_d = jmp_tgt;
    endcase
  end

  // Control FSM with registered request/halt/pulse outputs; commits architectural state in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      halted_q    <= 1'b0;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      cf_q        <= 1'b0;
      ip_q        <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
          end
        end
        S_FETCH: begin
          // Address comes straight from ip_q, which cannot change here, so it stays stable.
          if (imem_valid) begin
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          a_q         <= a_d;
          b_q         <= b_d;
          out_q       <= out_d;
          cf_q        <= cf_d;
          ip_q        <= ip_d;
          out_valid_q <= out_vld_d;
          if (op == OP_HALT) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else if (run) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = ip_q;
  assign out_port  = out_q;
  assign out_valid = out_valid_q;
  assign cf        = cf_q;
  assign halted    = halted_q;
  assign ip        = ip_q;

endmodule
